// File: rtl/divider_pkg.sv
// Shared types and magnitude helpers for the sequential signed divider.
// Helpers work at MAX_W bits; callers truncate to their operand width.
package divider_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_W         = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DIVIDE = 2'b01,
    FIXUP  = 2'b10,
    DONE   = 2'b11
  } state_e;

  // Two's-complement negation; low bits are correct for any narrower width.
  function automatic logic [MAX_W-1:0] negate_f(input logic [MAX_W-1:0] x);
    return ~x + MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] abs_f(input logic [MAX_W-1:0] x, input logic neg);
    return neg ? negate_f(x) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D, keep or restore.
// Purely combinational.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [2*WIDTH:0] rq_sh;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   trial;

  assign rq_sh = {r_i, q_i} << 1;
  assign r_sh  = rq_sh[2*WIDTH:WIDTH];
  assign q_sh  = rq_sh[WIDTH-1:0];
  assign trial = r_sh - {1'b0, d_i};

  // A clear trial MSB means D fit into the partial remainder.
  assign r_o = trial[WIDTH] ? r_sh : trial;
  assign q_o = q_sh | {{(WIDTH-1){1'b0}}, ~trial[WIDTH]};

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per clock,
// sign fix-up afterwards; results held from done until the next accepted start completes.
module seq_signed_divider
  import divider_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int CNTR_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             _reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e            state_q;
  logic [WIDTH:0]    r_q;
  logic [WIDTH-1:0]  q_q;
  logic [WIDTH-1:0]  d_q;
  logic [CNTR_W-1:0] cnt_q;
  logic              qneg_q;
  logic              rneg_q;
  logic              ovf_pend_q;
  logic [WIDTH-1:0]  quotient_q;
  logic [WIDTH-1:0]  remainder_q;
  logic              busy_q;
  logic              done_q;
  logic              dbz_q;
  logic              ovf_q;

  logic [WIDTH:0]    r_d;
  logic [WIDTH-1:0]  q_d;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_d),
    .q_o (q_d)
  );

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      ovf_pend_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              ovf_q       <= 1'b0;
              state_q     <= DONE;
            end else begin
              q_q        <= WIDTH'(abs_f(MAX_W'(dividend), dividend[WIDTH-1]));
              d_q        <= WIDTH'(abs_f(MAX_W'(divisor), divisor[WIDTH-1]));
              qneg_q     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              rneg_q     <= dividend[WIDTH-1];
              ovf_pend_q <= (dividend == MOST_NEG) && (divisor == '1);
              r_q        <= '0;
              cnt_q      <= '0;
              dbz_q      <= 1'b0;
              ovf_q      <= 1'b0;
              state_q    <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CNTR_W'(1);
          if (cnt_q == CNTR_W'(WIDTH - 1)) state_q <= FIXUP;
        end
        FIXUP: begin
          // MOST_NEG / -1 needs no special path: magnitude 2^(WIDTH-1) wraps to MOST_NEG.
          quotient_q  <= qneg_q ? WIDTH'(negate_f(MAX_W'(q_q))) : q_q;
          remainder_q <= rneg_q ? WIDTH'(negate_f(MAX_W'(r_q[WIDTH-1:0]))) : r_q[WIDTH-1:0];
          ovf_q       <= ovf_pend_q;
          done_q      <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          // Divide-by-zero arrives here with done still low and spends one extra cycle.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
